// File: rtl/sram_axi_arbiter_pkg.sv
// Shared state encodings and AXI ID constants for the SRAM-to-AXI arbiter.
// Types and constants only, so there is no timing or flow control here.
package sram_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wr_state_t;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

endpackage

// File: rtl/sram_axi_arbiter_if.sv
// Bundles the two SRAM-like requester ports and the single-beat AXI master port.
// The master modport is the arbiter's view; the slave modport is the pipeline and memory view.
interface sram_axi_arbiter_if;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready, rid, rdata, rvalid,
    output rready, awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready, bvalid,
    output bready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready, rid, rdata, rvalid,
    input  rready, awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_wr_fsm.sv
// Single-beat AXI write engine: AW and W are offered together and retire independently, then B is awaited.
// One cycle from start to AW/W valid; holds valid until each ready, idle reports when a new store may start.
module sram_axi_wr_fsm
  import sram_axi_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        awready,
  input  logic        wready,
  input  logic        bvalid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  output logic        bready,
  output logic        idle,
  output logic        b_done
);

  wr_state_t state, state_nxt;
  logic      aw_done, w_done;
  logic      aw_fire, w_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_nxt;
  end

  // Done flags only live inside W_AW; leaving that state clears them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != W_AW) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      awaddr <= req_addr;
      awsize <= {1'b0, req_size};
      wdata  <= req_wdata;
      wstrb  <= req_wstrb;
    end
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    idle      = 1'b0;
    b_done    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    case (state)
      W_IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = W_AW;
      end
      W_AW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        aw_fire = !aw_done && awready;
        w_fire  = !w_done && wready;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) begin
          b_done    = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI master between fetch and load/store, one outstanding transaction per requester, data reads win.
// addr_ok and data_ok are combinational; a requester stalls (addr_ok=0) while busy, its FSM is busy or a write hazard exists.
module sram_axi_arbiter #(
  parameter logic [3:0] ID_INST = sram_axi_arbiter_pkg::ID_INST,
  parameter logic [3:0] ID_DATA = sram_axi_arbiter_pkg::ID_DATA
) (
  input  logic               clk,
  input  logic               resetn,
  sram_axi_arbiter_if.master bus
);
  import sram_axi_arbiter_pkg::*;

  rd_state_t   rd_state, rd_state_nxt;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic [3:0]  arid_q;
  logic        arvalid_c, rready_c;
  logic        data_busy, inst_busy;
  logic        r_idle, w_idle, b_done, rd_done;
  logic        data_accept, data_rd_accept, data_wr_accept, inst_accept;
  logic        inst_hazard, data_rd_req;
  logic        inst_ok, data_ok;
  logic        unused_inst;

  assign unused_inst = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata};

  assign r_idle      = (rd_state == R_IDLE);
  assign data_rd_req = bus.data_sram_req && !bus.data_sram_wr;
  // A fetch must not overtake a pending store to the same word.
  assign inst_hazard = !w_idle && (bus.awaddr[31:2] == bus.inst_sram_addr[31:2]);

  assign data_accept    = resetn && bus.data_sram_req && !data_busy &&
                          (bus.data_sram_wr ? w_idle : r_idle);
  assign data_rd_accept = data_accept && !bus.data_sram_wr;
  assign data_wr_accept = data_accept && bus.data_sram_wr;
  assign inst_accept    = resetn && bus.inst_sram_req && !inst_busy && r_idle &&
                          !data_rd_req && !inst_hazard;

  assign rd_done = bus.rvalid && rready_c;
  assign inst_ok = rd_done && (bus.rid == ID_INST);
  assign data_ok = (rd_done && (bus.rid == ID_DATA)) || b_done;

  assign bus.inst_sram_addr_ok = inst_accept;
  assign bus.data_sram_addr_ok = data_accept;
  assign bus.inst_sram_data_ok = inst_ok;
  assign bus.data_sram_data_ok = data_ok;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.data_sram_rdata   = bus.rdata;

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arsize  = arsize_q;
  assign bus.arvalid = arvalid_c;
  assign bus.rready  = rready_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_state <= R_IDLE;
    else         rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (data_rd_accept) begin
      araddr_q <= bus.data_sram_addr;
      arsize_q <= {1'b0, bus.data_sram_size};
      arid_q   <= ID_DATA;
    end else if (inst_accept) begin
      araddr_q <= bus.inst_sram_addr;
      arsize_q <= {1'b0, bus.inst_sram_size};
      arid_q   <= ID_INST;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    arvalid_c    = 1'b0;
    rready_c     = 1'b0;
    case (rd_state)
      R_IDLE: if (data_rd_accept || inst_accept) rd_state_nxt = R_AR;
      R_AR: begin
        arvalid_c = 1'b1;
        if (bus.arready) rd_state_nxt = R_R;
      end
      R_R: begin
        rready_c = 1'b1;
        if (bus.rvalid) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Accept and completion of the same requester never coincide, so set/clear order is irrelevant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_busy <= 1'b0;
      inst_busy <= 1'b0;
    end else begin
      if (data_accept)  data_busy <= 1'b1;
      else if (data_ok) data_busy <= 1'b0;
      if (inst_accept)  inst_busy <= 1'b1;
      else if (inst_ok) inst_busy <= 1'b0;
    end
  end

  sram_axi_wr_fsm u_wr_fsm (
    .clk       (clk),
    .resetn    (resetn),
    .start     (data_wr_accept),
    .req_addr  (bus.data_sram_addr),
    .req_size  (bus.data_sram_size),
    .req_wdata (bus.data_sram_wdata),
    .req_wstrb (bus.data_sram_wstrb),
    .awready   (bus.awready),
    .wready    (bus.wready),
    .bvalid    (bus.bvalid),
    .awaddr    (bus.awaddr),
    .awsize    (bus.awsize),
    .awvalid   (bus.awvalid),
    .wdata     (bus.wdata),
    .wstrb     (bus.wstrb),
    .wvalid    (bus.wvalid),
    .bready    (bus.bready),
    .idle      (w_idle),
    .b_done    (b_done)
  );

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: drives requests and AXI responses at negedge, scoreboards data_ok returns.
module tb_sram_axi_arbiter;
  import sram_axi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_axi_arbiter_if bus ();

  sram_axi_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] rdata;
  } dexp_t;

  logic [31:0] inst_q[$];
  dexp_t       data_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_data(input logic is_wr, input logic [31:0] d);
    dexp_t e;
    e.is_wr = is_wr;
    e.rdata = d;
    data_q.push_back(e);
  endtask

  // Called at a negedge with the read FSM in R_AR; returns one negedge after the R beat.
  task automatic read_resp(input logic [3:0] id, input logic [31:0] d);
    bus.arready = 1'b1;
    cyc();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rid     = id;
    bus.rdata   = d;
    cyc();
    bus.rvalid  = 1'b0;
  endtask

  // Called at a negedge with the write FSM in W_AW; AW and W retire together, then B.
  task automatic write_resp();
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    cyc();
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b1;
    cyc();
    bus.bvalid  = 1'b0;
  endtask

  always @(negedge clk) begin
    dexp_t e;
    #2;
    if (bus.inst_sram_data_ok === 1'b1) begin
      if (inst_q.size() == 0) chk("inst_ok_expected", 32'(inst_q.size() != 0), 32'd1);
      else                    chk("inst_rdata_sb", bus.inst_sram_rdata, inst_q.pop_front());
    end
    if (bus.data_sram_data_ok === 1'b1) begin
      if (data_q.size() == 0) chk("data_ok_expected", 32'(data_q.size() != 0), 32'd1);
      else begin
        e = data_q.pop_front();
        if (e.is_wr) chk("data_ok_from_b", 32'(bus.bvalid), 32'd1);
        else         chk("data_rdata_sb", bus.data_sram_rdata, e.rdata);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.inst_sram_req = 1'b1;  bus.inst_sram_wr = 1'b0;  bus.inst_sram_size = 2'd2;
    bus.inst_sram_addr = 32'h0; bus.inst_sram_wstrb = 4'h0; bus.inst_sram_wdata = 32'h0;
    bus.data_sram_req = 1'b1;  bus.data_sram_wr = 1'b0;  bus.data_sram_size = 2'd2;
    bus.data_sram_addr = 32'h0; bus.data_sram_wstrb = 4'h0; bus.data_sram_wdata = 32'h0;
    bus.arready = 1'b0; bus.rid = 4'h0; bus.rdata = 32'h0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;

    // Reset state, with requests held high to show addr_ok is gated.
    cyc(); #1;
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_rready",  32'(bus.rready),  32'd0);
    chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_wvalid",  32'(bus.wvalid),  32'd0);
    chk("rst_bready",  32'(bus.bready),  32'd0);
    chk("rst_inst_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
    bus.inst_sram_req = 1'b0; bus.data_sram_req = 1'b0;
    cyc(); resetn = 1'b1;
    cyc();

    // Instruction read only.
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0000; bus.inst_sram_size = 2'd2;
    #1 chk("t1_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
    inst_q.push_back(32'hDEAD_BEEF);
    cyc(); bus.inst_sram_req = 1'b0;
    #1 chk("t1_arvalid", 32'(bus.arvalid), 32'd1);
    chk("t1_arid",   32'(bus.arid),   32'(ID_INST));
    chk("t1_arsize", 32'(bus.arsize), 32'd2);
    chk("t1_araddr", bus.araddr, 32'h1C00_0000);
    cyc(); bus.arready = 1'b1;
    #1 chk("t1_arvalid_hold", 32'(bus.arvalid), 32'd1);
    cyc(); bus.arready = 1'b0;
    #1 chk("t1_rready", 32'(bus.rready), 32'd1);
    cyc(); cyc();
    bus.rvalid = 1'b1; bus.rid = ID_INST; bus.rdata = 32'hDEAD_BEEF;
    #1 chk("t1_inst_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t1_inst_rdata", bus.inst_sram_rdata, 32'hDEAD_BEEF);
    chk("t1_data_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
    cyc(); bus.rvalid = 1'b0;
    #1 chk("t1_ok_pulse", 32'(bus.inst_sram_data_ok), 32'd0);
    chk("t1_rready_idle", 32'(bus.rready), 32'd0);

    // Same-cycle inst and data read: data wins.
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0010;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_size = 2'd0;
    bus.data_sram_addr = 32'h0000_0100;
    #1 chk("t2_data_addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    chk("t2_inst_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
    push_data(1'b0, 32'h0000_00AA);
    cyc(); bus.data_sram_req = 1'b0;
    #1 chk("t2_arid", 32'(bus.arid), 32'(ID_DATA));
    chk("t2_arsize", 32'(bus.arsize), 32'd0);
    chk("t2_araddr", bus.araddr, 32'h0000_0100);
    chk("t2_inst_blk_ar", 32'(bus.inst_sram_addr_ok), 32'd0);
    bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = ID_DATA; bus.rdata = 32'h0000_00AA;
    #1 chk("t2_data_data_ok", 32'(bus.data_sram_data_ok), 32'd1);
    chk("t2_inst_blk_r", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc(); bus.rvalid = 1'b0;
    #1 chk("t2_inst_after_idle", 32'(bus.inst_sram_addr_ok), 32'd1);
    inst_q.push_back(32'h1111_2222);
    cyc(); bus.inst_sram_req = 1'b0;
    #1 chk("t2_inst_arid", 32'(bus.arid), 32'(ID_INST));
    read_resp(ID_INST, 32'h1111_2222);

    // Store with W handshake before AW.
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_size = 2'd2;
    bus.data_sram_addr = 32'h0000_0200; bus.data_sram_wstrb = 4'b0011; bus.data_sram_wdata = 32'h0000_1234;
    #1 chk("t3_addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    push_data(1'b1, 32'h0);
    cyc(); bus.data_sram_req = 1'b0;
    #1 chk("t3_awvalid", 32'(bus.awvalid), 32'd1);
    chk("t3_wvalid", 32'(bus.wvalid), 32'd1);
    chk("t3_awaddr", bus.awaddr, 32'h0000_0200);
    chk("t3_awsize", 32'(bus.awsize), 32'd2);
    chk("t3_wdata", bus.wdata, 32'h0000_1234);
    chk("t3_wstrb", 32'(bus.wstrb), 32'b0011);
    bus.wready = 1'b1;
    cyc(); bus.wready = 1'b0;
    #1 chk("t3_wvalid_drop", 32'(bus.wvalid), 32'd0);
    chk("t3_awvalid_hold", 32'(bus.awvalid), 32'd1);
    bus.awready = 1'b1;
    cyc(); bus.awready = 1'b0;
    #1 chk("t3_awvalid_drop", 32'(bus.awvalid), 32'd0);
    chk("t3_bready", 32'(bus.bready), 32'd1);
    bus.bvalid = 1'b1;
    #1 chk("t3_data_ok", 32'(bus.data_sram_data_ok), 32'd1);
    chk("t3_no_inst_ok", 32'(bus.inst_sram_data_ok), 32'd0);
    cyc(); bus.bvalid = 1'b0;
    #1 chk("t3_bready_idle", 32'(bus.bready), 32'd0);

    // Write hazard: same word held until B, different word passes.
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0300;
    push_data(1'b1, 32'h0);
    cyc(); bus.data_sram_req = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    cyc(); bus.awready = 1'b0; bus.wready = 1'b0;
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h0000_0300;
    #1 chk("t4_hazard_blk0", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc();
    #1 chk("t4_hazard_blk1", 32'(bus.inst_sram_addr_ok), 32'd0);
    bus.bvalid = 1'b1;
    #1 chk("t4_hazard_blk_b", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc(); bus.bvalid = 1'b0;
    #1 chk("t4_hazard_clear", 32'(bus.inst_sram_addr_ok), 32'd1);
    inst_q.push_back(32'h3030_3030);
    cyc(); bus.inst_sram_req = 1'b0;
    read_resp(ID_INST, 32'h3030_3030);
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0300;
    push_data(1'b1, 32'h0);
    cyc(); bus.data_sram_req = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    cyc(); bus.awready = 1'b0; bus.wready = 1'b0;
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h0000_0304;
    #1 chk("t4_other_word", 32'(bus.inst_sram_addr_ok), 32'd1);
    inst_q.push_back(32'h3434_3434);
    cyc(); bus.inst_sram_req = 1'b0;
    bus.bvalid = 1'b1;
    cyc(); bus.bvalid = 1'b0;
    read_resp(ID_INST, 32'h3434_3434);

    // Ordering: store waits for the outstanding load.
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_size = 2'd2;
    bus.data_sram_addr = 32'h0000_0400;
    #1 chk("t5_load_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    push_data(1'b0, 32'h4444_0000);
    cyc(); bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0500; bus.data_sram_wdata = 32'h5555_5555;
    bus.data_sram_wstrb = 4'hF;
    #1 chk("t5_store_blk_ar", 32'(bus.data_sram_addr_ok), 32'd0);
    bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = ID_DATA; bus.rdata = 32'h4444_0000;
    #1 chk("t5_store_blk_r", 32'(bus.data_sram_addr_ok), 32'd0);
    cyc(); bus.rvalid = 1'b0;
    #1 chk("t5_store_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    push_data(1'b1, 32'h0);
    cyc(); bus.data_sram_req = 1'b0;
    #1 chk("t5_awaddr", bus.awaddr, 32'h0000_0500);
    write_resp();

    // Asynchronous reset while in R_R.
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0020;
    #1 chk("t6_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0;
    #1 chk("t6_in_rr", 32'(bus.rready), 32'd1);
    bus.inst_sram_req = 1'b1; bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0;
    bus.rvalid = 1'b1; bus.rid = ID_INST; bus.rdata = 32'h6666_6666;
    resetn = 1'b0;
    #1 chk("t6_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t6_rready", 32'(bus.rready), 32'd0);
    chk("t6_inst_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
    chk("t6_data_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
    chk("t6_inst_data_ok", 32'(bus.inst_sram_data_ok), 32'd0);
    chk("t6_data_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
    cyc(); bus.inst_sram_req = 1'b0; bus.data_sram_req = 1'b0; bus.rvalid = 1'b0;
    cyc(); resetn = 1'b1;
    #1 chk("t6_post_awvalid", 32'(bus.awvalid), 32'd0);
    chk("t6_post_arvalid", 32'(bus.arvalid), 32'd0);
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1C00_0040;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h0000_0700;
    #1 chk("t6_inst_reaccept", 32'(bus.inst_sram_addr_ok), 32'd1);
    chk("t6_data_reaccept", 32'(bus.data_sram_addr_ok), 32'd1);
    inst_q.push_back(32'h4040_4040);
    push_data(1'b1, 32'h0);
    cyc(); bus.inst_sram_req = 1'b0; bus.data_sram_req = 1'b0;
    write_resp();
    read_resp(ID_INST, 32'h4040_4040);

    cyc();
    chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
    chk("data_q_drained", 32'(data_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
